// File: rtl/hyp_seq_ctrl_if.sv
// Handshake/data bundle for hyp_seq_ctrl: the master side issues start with
// operands and an enable, the slave side (the sequencer) reports busy/done/result.
interface hyp_seq_ctrl_if;
  logic       ena;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       busy;
  logic       done;
  logic [8:0] result;

  modport master (output ena, start, x, y, input busy, done, result);
  modport slave  (input ena, start, x, y, output busy, done, result);
endinterface

// File: rtl/hyp_seq_ctrl.sv
// hyp_seq_ctrl: sequential hypotenuse, result = sqrt(x*x + y*y).
// Squares are built with one shared shift-add accumulator (8 edges each),
// then a 9-step restoring square root runs on the 17-bit sum.
// Optional macro HYP_ROUND_EN: round the root to nearest instead of floor.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// SQX   | accumulate x*x, one bit of x per enabled edge (LSB first)
// SQY   | accumulate y*y, then add it to the sum
// SQRT  | restoring square root, test bit 1<<16 down to 1<<0
// DONE  | result valid, done high for this one cycle
module hyp_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  hyp_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SQX, SQY, SQRT, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  x_reg, y_reg;
  logic [3:0]  cnt;
  logic [15:0] acc;
  logic [16:0] sum;
  logic [17:0] root;
  logic [8:0]  res_reg;

  logic [7:0]  mul_op;
  logic [15:0] addend;
  logic [15:0] acc_nxt;
  logic [17:0] tbit;
  logic [17:0] trial;
  logic        fits;
  logic [16:0] rem_nxt;
  logic [17:0] root_nxt;
  logic [8:0]  res_fin;

  // Shift-add step for the operand being squared, plus one root iteration.
  always_comb begin
    mul_op   = (state == SQY) ? y_reg : x_reg;
    addend   = mul_op[cnt[2:0]] ? (16'(mul_op) << cnt[2:0]) : 16'd0;
    acc_nxt  = acc + addend;
    tbit     = 18'd1 << (5'd16 - {cnt, 1'b0});
    trial    = root + tbit;
    fits     = ({1'b0, sum} >= trial);
    rem_nxt  = fits ? (sum - trial[16:0]) : sum;
    root_nxt = fits ? ((root >> 1) + tbit) : (root >> 1);
`ifdef HYP_ROUND_EN
    // Remainder above the root means sqrt lies at or beyond root + 0.5.
    res_fin  = root_nxt[8:0] + (({1'b0, rem_nxt} > root_nxt) ? 9'd1 : 9'd0);
`else
    res_fin  = root_nxt[8:0];
`endif
  end

  // State register; ena=0 freezes the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       state <= IDLE;
    else if (bus.ena) state <= state_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)   state_nxt = SQX;
      SQX:     if (cnt == 4'd7) state_nxt = SQY;
      SQY:     if (cnt == 4'd7) state_nxt = SQRT;
      SQRT:    if (cnt == 4'd8) state_nxt = DONE;
      DONE:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, accumulator, sum/remainder, root and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      y_reg   <= '0;
      cnt     <= '0;
      acc     <= '0;
      sum     <= '0;
      root    <= '0;
      res_reg <= '0;
    end else if (bus.ena) begin
      case (state)
        IDLE: if (bus.start) begin
          x_reg <= bus.x;
          y_reg <= bus.y;
          cnt   <= '0;
          acc   <= '0;
          sum   <= '0;
          root  <= '0;
        end
        SQX: if (cnt == 4'd7) begin
          sum <= {1'b0, acc_nxt};
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
        end
        SQY: if (cnt == 4'd7) begin
          sum <= sum + {1'b0, acc_nxt};
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
        end
        SQRT: begin
          sum  <= rem_nxt;
          root <= root_nxt;
          if (cnt == 4'd8) begin
            res_reg <= res_fin;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res_reg;

endmodule

// File: tb/tb_hyp_seq_ctrl.sv
// Scoreboard bench for hyp_seq_ctrl: the stimulus side pushes the expected
// result and the cycle at which done must appear; an independent monitor
// pops and compares whenever done is seen, and checks result stability.
module tb_hyp_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   held = 0;

  typedef struct {
    int res;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  hyp_seq_ctrl_if bus ();

  hyp_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: exact integer root of the sum of squares, found by search.
  function automatic int hyp_ref(input int a, input int b);
    int s;
    int r;
    s = a * a + b * b;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
`ifdef HYP_ROUND_EN
    if (s - r * r > r) r++;
`endif
    return r;
  endfunction

  // Monitor: compare on done, otherwise result must hold its last value.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held = 0;
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", int'(bus.result), e.res);
        check("done_cycle", cyc, e.cyc);
        held = e.res;
      end
    end else begin
      check("result_hold", int'(bus.result), held);
    end
  end

  // One request: optional stall window, extra ignored starts, optional reset.
  task automatic run_op(input logic [7:0] xa, input logic [7:0] ya,
                        input int st_at, input int st_len,
                        input bit extra, input int rst_at);
    int   e0;
    int   lat;
    exp_t e;
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);
    bus.ena   = 1'b1;
    bus.start = 1'b1;
    bus.x     = xa;
    bus.y     = ya;
    e0  = cyc + 1;
    lat = 25 + st_len;
    e.res = hyp_ref(int'(xa), int'(ya));
    e.cyc = e0 + lat;
    exp_q.push_back(e);
    for (int t = 0; t <= lat; t++) begin
      @(negedge clk);
      bus.ena   = !(t >= st_at && t < st_at + st_len);
      bus.start = extra && (t == 5 || t == lat);
      bus.x     = 8'($urandom);
      bus.y     = 8'($urandom);
      check("busy_run", int'(bus.busy), 1);
      if (t == rst_at) begin
        bus.start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_result", int'(bus.result), 0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.ena = 1'b1;
        return;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.ena   = 1'b1;
    check("busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ena   = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    #1;
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_result", int'(bus.result), 0);
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    bus.ena = 1'b1;

    run_op(8'd3,   8'd4,   0,  0, 1'b0, -1);
    run_op(8'd255, 8'd255, 0,  0, 1'b0, -1);
    run_op(8'd0,   8'd0,   0,  0, 1'b0, -1);
    run_op(8'd255, 8'd0,   0,  0, 1'b0, -1);
    run_op(8'd6,   8'd8,   10, 4, 1'b0, -1);
    run_op(8'd3,   8'd4,   0,  0, 1'b1, -1);
    run_op(8'd1,   8'd1,   0,  0, 1'b0, -1);
    run_op(8'd1,   8'd2,   0,  0, 1'b0, -1);
    run_op(8'd200, 8'd100, 0,  0, 1'b0, 20);
    run_op(8'd5,   8'd12,  0,  0, 1'b0, -1);

    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(1, 20)),
             int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
